// File: rtl/eth_tx_arbiter_if.sv
// AXI-Stream bundle used for both source ports and the MAC-facing port of eth_tx_arbiter.
`timescale 1ns/1ps
interface eth_tx_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the 10G MAC TX stream, with inter-frame gap and max-length abort.
// Optional statistics counters (frames0_cnt, frames1_cnt, abort_cnt) are enabled by defining TX_ARB_STATS_EN.
`timescale 1ns/1ps
module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BEATS  = 190,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk156,
    input  logic                    sys_rst,
    eth_tx_arbiter_if.slave         s0_axis,
    eth_tx_arbiter_if.slave         s1_axis,
    eth_tx_arbiter_if.master        m_axis,
    output logic [1:0]              grant
`ifdef TX_ARB_STATS_EN
    ,
    output logic [31:0]             frames0_cnt,
    output logic [31:0]             frames1_cnt,
    output logic [31:0]             abort_cnt
`endif
);

    localparam int BEAT_W = $clog2(MAX_BEATS);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP,
        ST_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                last_winner_q, last_winner_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic                  sel;
    logic                  src_tvalid;
    logic [DATA_WIDTH-1:0] src_tdata;
    logic [KEEP_WIDTH-1:0] src_tkeep;
    logic                  src_tlast;
    logic                  src_tuser;
    logic                  src_tready;
    logic                  force_last;

    // Owner select comes from the registered grant, so the mux never depends on a request.
    assign sel        = grant_q[1];
    assign src_tvalid = sel ? s1_axis.tvalid : s0_axis.tvalid;
    assign src_tdata  = sel ? s1_axis.tdata  : s0_axis.tdata;
    assign src_tkeep  = sel ? s1_axis.tkeep  : s0_axis.tkeep;
    assign src_tlast  = sel ? s1_axis.tlast  : s0_axis.tlast;
    assign src_tuser  = sel ? s1_axis.tuser  : s0_axis.tuser;

    assign s0_axis.tready = src_tready & ~sel;
    assign s1_axis.tready = src_tready &  sel;
    assign grant          = grant_q;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        last_winner_d = last_winner_q;
        beat_cnt_d    = beat_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        src_tready    = 1'b0;
        force_last    = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s0_axis.tvalid && (!s1_axis.tvalid || last_winner_q)) begin
                    grant_d       = 2'b01;
                    last_winner_d = 1'b0;
                    state_d       = ST_PASS;
                end else if (s1_axis.tvalid) begin
                    grant_d       = 2'b10;
                    last_winner_d = 1'b1;
                    state_d       = ST_PASS;
                end
            end

            ST_PASS: begin
                force_last    = (beat_cnt_q == LAST_BEAT) && !src_tlast;
                m_axis.tvalid = src_tvalid;
                m_axis.tdata  = src_tdata;
                m_axis.tkeep  = src_tkeep;
                m_axis.tlast  = src_tlast | force_last;
                m_axis.tuser  = src_tuser | force_last;
                src_tready    = m_axis.tready;
                if (src_tvalid && m_axis.tready) begin
                    if (src_tlast) begin
                        beat_cnt_d = '0;
                        gap_cnt_d  = '0;
                        grant_d    = 2'b00;
                        state_d    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else if (force_last) begin
                        beat_cnt_d = '0;
                        state_d    = ST_DROP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            // Swallow the rest of an aborted frame; the MAC already saw tlast/tuser.
            ST_DROP: begin
                src_tready = 1'b1;
                if (src_tvalid && src_tlast) begin
                    gap_cnt_d = '0;
                    grant_d   = 2'b00;
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            last_winner_q <= 1'b1;
            beat_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_winner_q <= last_winner_d;
            beat_cnt_q    <= beat_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

`ifdef TX_ARB_STATS_EN
    logic        pass_hs;
    logic        frame_done;
    logic [31:0] frames0_q, frames1_q, abort_q;

    // A forced-tlast beat also closes a frame, so it counts towards the owner's total.
    assign pass_hs    = (state_q == ST_PASS) && src_tvalid && m_axis.tready;
    assign frame_done = pass_hs && m_axis.tlast;

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            frames0_q <= '0;
            frames1_q <= '0;
            abort_q   <= '0;
        end else begin
            if (frame_done && !sel && (frames0_q != '1)) frames0_q <= frames0_q + 1'b1;
            if (frame_done &&  sel && (frames1_q != '1)) frames1_q <= frames1_q + 1'b1;
            if (pass_hs && force_last && (abort_q != '1)) abort_q <= abort_q + 1'b1;
        end
    end

    assign frames0_cnt = frames0_q;
    assign frames1_cnt = frames1_q;
    assign abort_cnt   = abort_q;
`endif

endmodule
